uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Parametrised successor UART transmitter for the UART controller.
- Accepts parallel words through a valid/ready push interface into an internal TX FIFO.
- Serialises each word on uart_txd with per-frame configurable data length (5..DATA_W bits), parity mode and 1/2 stop bits.
- Contains its own 16x-oversample baud divider.
- Sits between the register/bus interface and the TX pin.

Parameters:
DATA_W, 8, maximum data bits per frame (legal 5..9); FIFO word width.
FIFO_DEPTH, 4, TX FIFO entries; power of 2, >=2.
DIV_W, 16, width of cfg_div.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
cfg_div  input  DIV_W  baud divider; one sample tick every cfg_div+1 clocks.
cfg_txen  input  1  transmit enable; gates frame start only.
cfg_dlen  input  4  data bits per frame minus 1; values below 4 treated as 4; values above DATA_W-1 treated as DATA_W-1.
cfg_parity  input  2  00 none, 01 even, 10 odd, 11 none.
cfg_nstop  input  1  0: one stop bit; 1: two stop bits.
tx_valid  input  1  push request.
tx_data  input  DATA_W  push word; LSB transmitted first; bits above dlen ignored.
tx_ready  output  1  FIFO not full.
tx_busy  output  1  frame in progress (state != IDLE).
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
uart_txd  output  1  serial line; idle high.

Behaviour:
Reset (rst=1 at a clock edge):
- FIFO emptied: fifo_level=0, tx_ready=1.
- State=IDLE, tx_busy=0, uart_txd=1.
- Baud counter and bit counters cleared.
- Applies mid-frame: the line returns high on the next cycle.

FIFO:
- Push when tx_valid & tx_ready. Pushes are accepted regardless of cfg_txen.
- tx_ready = (fifo_level != FIFO_DEPTH), combinational from level.
- Pop when IDLE & cfg_txen & fifo non-empty.
- Simultaneous push and pop: level unchanged and data order preserved. This is only possible when not full.
- Pointers wrap modulo FIFO_DEPTH.

Baud:
- div_cnt counts 0..cfg_div. Tick when div_cnt==cfg_div, then div_cnt goes to 0.
- div_cnt is cleared on pop.
- One bit lasts 16 ticks = 16*(cfg_div+1) clocks.

Config latching:
- On pop, latch cfg_dlen, cfg_parity and cfg_nstop together with the data word.
- Config changes mid-frame have no effect on that frame.

States: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on pop.
- START -> DATA after 16 ticks.
- DATA -> PARITY after dlen+1 bits if parity is enabled; otherwise DATA -> STOP.
- PARITY -> STOP after 16 ticks.
- STOP -> IDLE after 1 or 2 bit periods.
- uart_txd: START=0; DATA = current LSB of shift register, shifting right each bit; PARITY = even: XOR of transmitted data bits, odd: inverted XOR; STOP=1; IDLE=1.
- uart_txd is registered.

Latency:
- Push at edge T into an empty FIFO, with IDLE and txen=1: pop at edge T+1, uart_txd=0 from T+2.
- Back-to-back frames: after STOP ends (IDLE at edge E), the next pop occurs at E. The line therefore stays high for exactly one clock between frames.

cfg_txen deasserted mid-frame: the current frame completes, then the block stays in IDLE with the FIFO retained.

Optional Feature:
Macro: UART_TX_BREAK_EN.

Defined:
- Adds input port cfg_break (1 bit).
- When cfg_break=1 in IDLE: uart_txd driven 0, no pops, tx_busy=0.
- If cfg_break is asserted mid-frame, the frame completes first, then the break is applied.
- On deassertion, the line returns to 1 the next cycle and normal pops resume the cycle after.

Not defined:
- cfg_break port absent.
- Line is always high in IDLE.

Test Plan:
1. Push 0xA5 once (cfg_div=0, dlen=7, parity=00, nstop=0, txen=1) -> uart_txd=0 from T+2 for 16 clks, then 1,0,1,0,0,1,0,1 (16 clks each), then 1 for 16 clks; tx_busy high for 160 clks.
2. Same word, parity=01 then 10 -> parity bit 0 (even) / 1 (odd) after the 8th data bit; frame length 176 clks.
3. dlen=4, nstop=1, push 0x1F, cfg_div=2 -> start + 5 ones + 2 stop bits, each bit 48 clks; total 384 clks.
4. txen=0, push 5 words (FIFO_DEPTH=4) -> fifo_level=4, tx_ready=0 and the 5th word dropped; txen=1 -> 4 frames sent in push order, each separated by one idle-high clock, level decrements on each pop.
5. Change cfg_dlen from 7 to 4 mid-frame -> current frame still 8 data bits; next frame uses 5.
6. Assert rst during a DATA bit -> next cycle uart_txd=1, tx_busy=0, fifo_level=0, tx_ready=1; with UART_TX_BREAK_EN defined, cfg_break=1 in IDLE -> uart_txd=0 and queued data held until release.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_if
// Push-side handshake bundle for uart_tx_fifo.
//   tx_valid : producer has a word to push
//   tx_data  : word to push, LSB is the first bit on the line
//   tx_ready : TX FIFO can accept a word this cycle (not full)
// Modports:
//   master : producer side (register/bus interface)
//   slave  : uart_tx_fifo side
// -----------------------------------------------------------------------------
interface uart_tx_fifo_if #(
    parameter int DATA_W = 8
);
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// UART transmitter with an internal TX FIFO and a 16x-oversample baud divider.
// Words pushed over tx_if are queued, then serialised LSB first on uart_txd as
// start bit, 5..DATA_W data bits, optional parity bit and 1 or 2 stop bits.
// Frame format (dlen, parity, nstop) is captured when a word leaves the FIFO,
// so configuration changes only affect frames that have not yet started.
//
// Ports:
//   clk        : clock, all logic on the rising edge
//   rst        : synchronous active-high reset
//   cfg_div    : baud divider, one sample tick every cfg_div+1 clocks
//   cfg_txen   : allows new frames to start (a running frame always completes)
//   cfg_dlen   : data bits minus 1, clamped to 4..DATA_W-1
//   cfg_parity : 00 none, 01 even, 10 odd, 11 none
//   cfg_nstop  : 0 one stop bit, 1 two stop bits
//   cfg_break  : (UART_TX_BREAK_EN only) hold the line low while idle
//   tx_if      : push handshake (tx_valid / tx_data / tx_ready)
//   tx_busy    : a frame is in progress
//   fifo_level : current FIFO occupancy
//   uart_txd   : registered serial output, idle high
//
// Build option: define UART_TX_BREAK_EN to add the cfg_break input.
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_W-1:0]              cfg_div,
    input  logic                          cfg_txen,
    input  logic [3:0]                    cfg_dlen,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_nstop,
`ifdef UART_TX_BREAK_EN
    input  logic                          cfg_break,
`endif
    uart_tx_fifo_if.slave                 tx_if,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          uart_txd
);
    localparam int         PTR_W    = $clog2(FIFO_DEPTH);
    localparam int         LVL_W    = PTR_W + 1;
    localparam logic [3:0] DLEN_MAX = 4'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state_reg, state_next;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0]  level_reg, level_next;

    logic [DIV_W-1:0]  div_cnt_reg, div_cnt_next;
    logic [3:0]        tick_cnt_reg, tick_cnt_next;
    logic [3:0]        bit_cnt_reg, bit_cnt_next;
    logic              stop_cnt_reg, stop_cnt_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic              par_reg, par_next;
    logic [3:0]        dlen_reg, dlen_next;
    logic [1:0]        parity_reg, parity_next;
    logic              nstop_reg, nstop_next;
    logic              txd_reg, txd_next;

    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              tick;
    logic              bit_end;
    logic              parity_en;
    logic              hold_idle;
    logic              idle_level;
    logic [3:0]        dlen_eff;

    // -------------------------------------------------------------------------
    // Optional break: line forced low while idle. The registered copy delays
    // the first pop by one cycle after release so the line shows a high level
    // before any start bit.
    // -------------------------------------------------------------------------
`ifdef UART_TX_BREAK_EN
    logic break_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            break_reg <= 1'b0;
        end else begin
            break_reg <= cfg_break;
        end
    end

    assign hold_idle  = cfg_break || break_reg;
    assign idle_level = !cfg_break;
`else
    assign hold_idle  = 1'b0;
    assign idle_level = 1'b1;
`endif

    // -------------------------------------------------------------------------
    // FIFO control
    // -------------------------------------------------------------------------
    assign fifo_full      = (level_reg == LVL_W'(FIFO_DEPTH));
    assign tx_if.tx_ready = !fifo_full;
    assign push           = tx_if.tx_valid && !fifo_full;
    assign pop            = (state_reg == IDLE) && cfg_txen &&
                            (level_reg != '0) && !hold_idle;

    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + LVL_W'(1);
            2'b01:   level_next = level_reg - LVL_W'(1);
            default: level_next = level_reg;
        endcase
    end

    // Storage has no reset so it maps onto RAM; the read port is only
    // consumed through shift_reg, which registers it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= tx_if.tx_data;
        end
    end

    // -------------------------------------------------------------------------
    // Frame format capture helpers
    // -------------------------------------------------------------------------
    always_comb begin
        dlen_eff = cfg_dlen;
        if (cfg_dlen < 4'd4) begin
            dlen_eff = 4'd4;
        end else if (cfg_dlen > DLEN_MAX) begin
            dlen_eff = DLEN_MAX;
        end
    end

    // Parity only for codes 01 and 10; 00 and 11 both mean none.
    assign parity_en = parity_reg[0] ^ parity_reg[1];

    // >= rather than == so a divider lowered mid-frame cannot strand the
    // counter above the new terminal value.
    assign tick    = (div_cnt_reg >= cfg_div);
    assign bit_end = tick && (tick_cnt_reg == 4'hF);

    // -------------------------------------------------------------------------
    // Next-state / datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        div_cnt_next  = div_cnt_reg;
        tick_cnt_next = tick_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        stop_cnt_next = stop_cnt_reg;
        shift_next    = shift_reg;
        par_next      = par_reg;
        dlen_next     = dlen_reg;
        parity_next   = parity_reg;
        nstop_next    = nstop_reg;

        if (state_reg != IDLE) begin
            if (tick) begin
                div_cnt_next  = '0;
                tick_cnt_next = tick_cnt_reg + 4'd1;
            end else begin
                div_cnt_next  = div_cnt_reg + DIV_W'(1);
            end
        end

        case (state_reg)
            IDLE: begin
                div_cnt_next  = '0;
                tick_cnt_next = '0;
                bit_cnt_next  = '0;
                stop_cnt_next = 1'b0;
                if (pop) begin
                    state_next  = START;
                    shift_next  = mem[rd_ptr_reg];
                    par_next    = 1'b0;
                    dlen_next   = dlen_eff;
                    parity_next = cfg_parity;
                    nstop_next  = cfg_nstop;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_next   = shift_reg >> 1;
                    par_next     = par_reg ^ shift_reg[0];
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    if (bit_cnt_reg == dlen_reg) begin
                        state_next = parity_en ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (nstop_reg && !stop_cnt_reg) begin
                        stop_cnt_next = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Line level follows the current state; the output register adds one
    // clock, which is why a pop at edge T shows the start bit from T+2.
    always_comb begin
        txd_next = 1'b1;
        case (state_reg)
            IDLE:    txd_next = idle_level;
            START:   txd_next = 1'b0;
            DATA:    txd_next = shift_reg[0];
            PARITY:  txd_next = par_reg ^ parity_reg[1];
            STOP:    txd_next = 1'b1;
            default: txd_next = 1'b1;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            div_cnt_reg  <= '0;
            tick_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            shift_reg    <= '0;
            par_reg      <= 1'b0;
            dlen_reg     <= 4'd4;
            parity_reg   <= 2'b00;
            nstop_reg    <= 1'b0;
            txd_reg      <= 1'b1;
        end else begin
            state_reg    <= state_next;
            level_reg    <= level_next;
            div_cnt_reg  <= div_cnt_next;
            tick_cnt_reg <= tick_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            stop_cnt_reg <= stop_cnt_next;
            shift_reg    <= shift_next;
            par_reg      <= par_next;
            dlen_reg     <= dlen_next;
            parity_reg   <= parity_next;
            nstop_reg    <= nstop_next;
            txd_reg      <= txd_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    assign tx_busy    = (state_reg != IDLE);
    assign fifo_level = level_reg;
    assign uart_txd   = txd_reg;

endmodule
